// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a division (sampled in IDLE)
//   signed_div 1 = DIV (two's complement), 0 = DIVU; sampled with start
//   a, b       dividend / divisor; sampled with start
//   cancel     flush/exception, aborts any operation in progress
//   stall      holds the pipeline while the operation is unfinished
//   ready      1-cycle pulse, hi_o/lo_o valid
//   hi_o       remainder
//   lo_o       quotient
//   we         HI/LO write enables, 2'b11 with ready
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [1:0]       we
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div_b;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign accept = (state == IDLE) && start && !cancel;
    assign finish = (state == DONE) && !cancel;

    // Magnitudes are only taken for DIV; DIVU passes raw operands through.
    assign a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
    assign b_abs = (signed_div && b[WIDTH-1]) ? -b : b;

    // Shifted partial remainder (with the next dividend bit) minus divisor.
    // One extra guard bit makes the MSB a clean borrow flag.
    assign trial = {1'b0, rem, quo[WIDTH-1]} - {2'b00, div_b};

    assign quo_fix = q_neg ? -quo : quo;
    assign rem_fix = r_neg ? -rem : rem;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall = 1'b0;
        ready = 1'b0;
        we    = 2'b00;
        hi_o  = hi_q;
        lo_o  = lo_q;
        case (state)
            IDLE: stall = accept && rst_n;
            BUSY: stall = 1'b1;
            DONE: begin
                if (!cancel) begin
                    ready = 1'b1;
                    we    = 2'b11;
                    hi_o  = rem_fix;
                    lo_o  = quo_fix;
                end
            end
            default: ;
        endcase
    end

    // Working registers and iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            div_b <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= a_abs;
            div_b <= b_abs;
            q_neg <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg <= signed_div && a[WIDTH-1];
        end else if (state == BUSY && !cancel) begin
            cnt <= cnt + 1'b1;
            if (trial[WIDTH+1]) begin
                // Negative: restore, shift in a 0 quotient bit.
                rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Held results: only updated by a completed, non-cancelled operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (finish) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
        end
    end

endmodule
